product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
Downstream consumer of the 4x4 Wallace-tree multiplier's 8-bit product. It accumulates a block of products into a wide sum using a valid/ready handshake. A block closes on in_last or when MAX_LEN beats have been accepted, whichever comes first. The closed block is presented as a registered result (sum, beat count, overflow flag) on a second valid/ready handshake. This forms the accumulate half of the datapath's MAC path.

Parameters:
PROD_W, 8, width of the incoming product; matches the multiplier's prod output
ACC_W, 16, accumulator and result width; must be >= PROD_W
MAX_LEN, 16, maximum beats per block; must be >= 1
SATURATE, 1, 1 = clamp the sum at 2^ACC_W-1 on overflow; 0 = wrap modulo 2^ACC_W
CNT_W, $clog2(MAX_LEN+1), beat-count width (derived; do not override)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  product beat is valid
in_ready  out  1  block can accept a beat
in_prod  in  PROD_W  unsigned product from the multiplier
in_last  in  1  marks the final beat of a block; sampled only on handshake
out_valid  out  1  result is valid
out_ready  in  1  downstream accepts the result
out_sum  out  ACC_W  accumulated (possibly saturated) sum
out_count  out  CNT_W  number of beats in the block (1..MAX_LEN)
out_ovf  out  1  sticky: a carry out of ACC_W occurred during the block

Behaviour:
- Reset is synchronous and active-high on rst; the block has one clock, clk. Reset dominates all other inputs. Values after reset:
  - state=ACCUM, acc=0, cnt=0, ovf=0
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1
- A reset asserted mid-block or while the result is held discards the block. No result is emitted.
- FSM has two states: ACCUM and HOLD.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready: compute acc' = acc + zero-extended in_prod at ACC_W+1 bits.
    - If bit ACC_W of acc' is set: ovf is set (sticky for the block). acc becomes all-ones if SATURATE=1, else acc'[ACC_W-1:0].
    - Once saturated, acc stays all-ones for the rest of the block.
    - cnt increments.
  - Close condition: accepted beat has in_last=1, or cnt+1==MAX_LEN.
  - On close:
    - out_sum, out_count and out_ovf take the post-update values.
    - out_valid=1 and state goes to HOLD on the next edge.
    - Result latency is 1 cycle after the closing handshake.
- HOLD:
  - in_ready=0 and out_valid=1.
  - Outputs are held stable while out_ready=0.
  - On out_ready=1: out_valid=0, acc/cnt/ovf are cleared, and state returns to ACCUM on the next edge.
  - out_sum, out_count and out_ovf keep their last values after the handshake.
  - A beat presented in the same cycle as the out handshake is not accepted, because in_ready=0.
- Throughput: one bubble cycle per block minimum. A 1-beat block completes its full cycle in 2 clocks.
- in_prod and in_last are ignored when in_valid=0 or in_ready=0.
- in_last on a beat that also reaches MAX_LEN gives a single close, not two.
- A zero-valued product still counts as a beat.
- No combinational path from any input to in_ready or out_valid. Both derive from state only.

Decomposition:
- Shared package mac_pkg:
  - state enum acc_state_t {ACCUM, HOLD}
  - default widths: MAC_PROD_W=8, MAC_ACC_W=16, MAC_MAX_LEN=16
- Sub-module sat_add:
  - parameterized ACC_W, B_W, SATURATE
  - inputs: a[ACC_W], b[B_W]
  - outputs: sum[ACC_W], carry
  - purely combinational
  - instantiated once for the accumulator update

Test Plan:
- After reset, drive 4 beats of in_prod=225 (15*15) back-to-back, last on beat 4 -> out_valid the cycle after beat 4 with out_sum=900, out_count=4, out_ovf=0. in_ready=0 while out_valid=1.
- ACC_W=10, SATURATE=1: drive 5 beats of 225 with last on beat 5 -> out_sum=1023, out_count=5, out_ovf=1. Repeat with SATURATE=0 -> out_sum=101 (1125 mod 1024), out_ovf=1.
- MAX_LEN=16, drive 20 beats of in_prod=1 and never assert in_last -> first result out_sum=16, out_count=16. With out_ready=1, beats 17-20 form the next block, closed by in_last on beat 20: out_sum=4, out_count=4.
- Hold out_ready=0 for 3 cycles after a block of {3,5,7} -> out_sum=15, out_count=3, held stable. in_ready=0 throughout, and in_valid pulses are ignored. out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Accept 2 beats of 100, then assert rst for 1 cycle, then send 1 beat of 9 with last -> out_sum=9, out_count=1, out_ovf=0. No result is emitted for the aborted block.
- Single beat in_prod=0 with in_last=1 -> out_sum=0, out_count=1, out_ovf=0. Next beat accepted no earlier than 2 cycles after the first.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate datapath.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int MAC_PROD_W  = 8;
    localparam int MAC_ACC_W   = 16;
    localparam int MAC_MAX_LEN = 16;

endpackage

// File: rtl/sat_add.sv
// Combinational accumulator adder: zero-extends b, reports the carry out of ACC_W
// and optionally clamps the sum to all-ones when that carry occurs.
module sat_add #(
    parameter int ACC_W    = 16,
    parameter int B_W      = 8,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [B_W-1:0]   b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, a} + (ACC_W + 1)'(b);
    assign carry = full[ACC_W];
    assign sum   = ((SATURATE != 0) && carry) ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates blocks of multiplier products and presents each closed block as a
// registered result. Handshakes: a transfer happens on a rising edge where valid && ready.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W   = MAC_PROD_W,
    parameter int ACC_W    = MAC_ACC_W,
    parameter int MAX_LEN  = MAC_MAX_LEN,
    parameter int SATURATE = 1,
    parameter int CNT_W    = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              dbg_state
);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf;
    logic             ovf_next;
    logic             accept;
    logic             close;

    sat_add #(
        .ACC_W   (ACC_W),
        .B_W     (PROD_W),
        .SATURATE(SATURATE)
    ) u_add (
        .a    (acc),
        .b    (in_prod),
        .sum  (acc_next),
        .carry(carry)
    );

    // Both handshake outputs are pure functions of state, so no input reaches them combinationally.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign dbg_state = state;

    assign accept   = in_valid && in_ready;
    assign cnt_next = cnt + CNT_W'(1);
    assign ovf_next = ovf | carry;
    assign close    = in_last || (cnt_next == CNT_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                acc <= acc_next;
                cnt <= cnt_next;
                ovf <= ovf_next;
                if (close) begin
                    out_sum   <= acc_next;
                    out_count <= cnt_next;
                    out_ovf   <= ovf_next;
                    state     <= HOLD;
                end
            end
        end else begin
            // Result registers keep their values after the handshake; only the running block clears.
            if (out_ready) begin
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
                state <= ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (16-bit, 10-bit saturating,
// 10-bit wrapping) share stimulus; each has its own expected-result queue.
module tb_product_accumulator;

    localparam int W = 22;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [7:0] in_prod;

    logic       in_ready0, in_ready1, in_ready2;
    logic       out_valid0, out_valid1, out_valid2;
    logic [15:0] sum0;
    logic [9:0]  sum1, sum2;
    logic [4:0]  cnt0, cnt1, cnt2;
    logic        ovf0, ovf1, ovf2;
    logic        st0, st1, st2;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(16), .SATURATE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_prod(in_prod),
        .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_sum(sum0),
        .out_count(cnt0), .out_ovf(ovf0), .dbg_state(st0)
    );

    product_accumulator #(.ACC_W(10), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_prod(in_prod),
        .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready), .out_sum(sum1),
        .out_count(cnt1), .out_ovf(ovf1), .dbg_state(st1)
    );

    product_accumulator #(.ACC_W(10), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_prod(in_prod),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(sum2),
        .out_count(cnt2), .out_ovf(ovf2), .dbg_state(st2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int s0, input int s1, input int s2, input int c,
                            input logic o0, input logic o1, input logic o2);
        exp_q0.push_back({16'(s0), 5'(c), o0});
        exp_q1.push_back({16'(s1), 5'(c), o1});
        exp_q2.push_back({16'(s2), 5'(c), o2});
    endtask

    task automatic mon(input int idx, input logic [W-1:0] act);
        logic [W-1:0] e;
        bit have;
        have = 0;
        e = '0;
        if (idx == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1; end
        if (idx == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1; end
        if (idx == 2 && exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1; end
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL result%0d unexpected: sum=%0d count=%0d ovf=%0d",
                     idx, act[21:6], act[5:1], act[0]);
        end else if (act !== e) begin
            failures++;
            $display("FAIL result%0d got sum=%0d count=%0d ovf=%0d expected sum=%0d count=%0d ovf=%0d",
                     idx, act[21:6], act[5:1], act[0], e[21:6], e[5:1], e[0]);
        end
    endtask

    always @(negedge clk) if (!rst && out_valid0 && out_ready) mon(0, {sum0, cnt0, ovf0});
    always @(negedge clk) if (!rst && out_valid1 && out_ready) mon(1, {6'd0, sum1, cnt1, ovf1});
    always @(negedge clk) if (!rst && out_valid2 && out_ready) mon(2, {6'd0, sum2, cnt2, ovf2});

    task automatic send_beat(input logic [7:0] p, input logic l);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        while (!in_ready0 && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("send_timeout", 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (!out_valid0 && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("drain_timeout", 32'd1, 32'd0);
        step();
        out_ready = 1'b0;
        check("drain_out_valid", out_valid0, 0);
        check("drain_in_ready", in_ready0, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, out_valid0, 0);
        check({tag, "_in_ready"}, in_ready0, 1);
        check({tag, "_out_sum"}, sum0, 0);
        check({tag, "_out_count"}, cnt0, 0);
        check({tag, "_out_ovf"}, ovf0, 0);
        check({tag, "_state"}, st0, 0);
    endtask

    initial begin
        int waits;
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_reset("reset");

        // Four beats of 15*15.
        push_exp(900, 900, 900, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) send_beat(8'd225, i == 3);
        check("t1_latency_out_valid", out_valid0, 1);
        check("t1_in_ready_low", in_ready0, 0);
        drain();

        // Five beats of 225 overflow the 10-bit instances.
        push_exp(1125, 1023, 101, 5, 0, 1, 1);
        for (int i = 0; i < 5; i++) send_beat(8'd225, i == 4);
        drain();

        // Twenty beats of 1: MAX_LEN close, then in_last close.
        out_ready = 1'b1;
        push_exp(16, 16, 16, 16, 0, 0, 0);
        push_exp(4, 4, 4, 4, 0, 0, 0);
        for (int i = 0; i < 20; i++) send_beat(8'd1, i == 19);
        drain();

        // Result held under back-pressure while stray beats are offered.
        push_exp(15, 15, 15, 3, 0, 0, 0);
        send_beat(8'd3, 0);
        send_beat(8'd5, 0);
        send_beat(8'd7, 1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_prod = 8'd200; in_last = 1'b1;
            check("hold_out_valid", out_valid0, 1);
            check("hold_in_ready", in_ready0, 0);
            check("hold_out_sum", sum0, 15);
            check("hold_out_count", cnt0, 3);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        drain();

        // Reset mid-block discards the partial block.
        push_exp(9, 9, 9, 1, 0, 0, 0);
        send_beat(8'd100, 0);
        send_beat(8'd100, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("abort");
        send_beat(8'd9, 1);
        drain();

        // Zero-valued single beat, then measure spacing to the next accepted beat.
        out_ready = 1'b1;
        push_exp(0, 0, 0, 1, 0, 0, 0);
        push_exp(5, 5, 5, 1, 0, 0, 0);
        send_beat(8'd0, 1);
        in_valid = 1'b1; in_prod = 8'd5; in_last = 1'b1;
        waits = 0;
        while (!in_ready0 && waits < 100) begin
            step();
            waits++;
        end
        check("bubble_wait_cycles", waits, 1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        drain();

        repeat (3) step();
        check("queues_empty", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
